stream_demux_1ton: RTL and testbench
====================================

Name: stream_demux_1toN

Overview:
- Parametrised, registered 1-to-N stream demultiplexer; successor to the combinational 1:2 demux.
- Routes one input data stream to one of CHANNELS output streams, selected per transfer by a select field.
- Each output has a one-entry holding register with valid/ready handshake, so one stalled channel never corrupts or duplicates data.
- Sits between a single producer (e.g. an ingress parser) and per-channel consumers.

Parameters:
- WIDTH, 8, data width per transfer in bits (≥1).
- CHANNELS, 4, number of output channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W ≥ CHANNELS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input transfer valid.
- s_ready  output  1  block can accept the input transfer this cycle.
- s_data  input  WIDTH  input payload.
- s_sel  input  SEL_W  destination channel index.
- m_valid  output  CHANNELS  per-channel output valid (bit i = channel i).
- m_ready  input  CHANNELS  per-channel consumer ready.
- m_data  output  CHANNELS*WIDTH  per-channel payload; channel i at bits [i*WIDTH +: WIDTH].
- drop_cnt  output  8  saturating count of transfers dropped for out-of-range select.
- err  output  1  sticky flag: set on the first out-of-range drop, cleared only by rst.

Behaviour:
- Reset (rst=1 at a rising edge): m_valid=0, m_data=0, drop_cnt=0, err=0. rst overrides every simultaneous handshake. Data held mid-transfer is discarded.
- Input handshake: a transfer occurs when s_valid && s_ready at a rising edge.
- s_ready is combinational:
  - If s_sel < CHANNELS: s_ready = !m_valid[s_sel] || m_ready[s_sel]. This is a combinational path from m_ready to s_ready.
  - If s_sel ≥ CHANNELS: s_ready = 1.
  - s_ready does not depend on s_valid.
- Accepted, in-range transfer: on the same edge, m_data[s_sel] <= s_data and m_valid[s_sel] <= 1. Latency is 1 cycle from input handshake to m_valid.
- Output handshake on channel i: m_valid[i] && m_ready[i] at an edge. m_valid[i] then clears unless a new transfer to i is accepted on the same edge.
- Simultaneous drain and refill of channel i: the register loads the new data and m_valid[i] stays 1. This gives full throughput of 1 transfer/cycle per channel.
- Channel independence: the holding registers are independent. A stalled channel j (m_valid[j]=1, m_ready[j]=0) blocks only inputs with s_sel=j.
- Stability: while m_valid[i]=1 and m_ready[i]=0, m_data[i] must stay stable.
- Ordering: transfers to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Out-of-range select (only possible when CHANNELS < 2**SEL_W):
  - The transfer is accepted and discarded. No m_valid changes.
  - drop_cnt increments and saturates at 255.
  - err <= 1.
- Upstream contract: s_data and s_sel must be held while s_valid=1 and s_ready=0. The block does not check this.
- Idle: with s_valid=0, channel registers change only through output handshakes.
- No internal FSM beyond the per-channel full/empty bits. Each channel has 2 states: EMPTY → FULL on load; FULL → EMPTY on drain without refill; FULL → FULL on drain with refill or on stall.

Test Plan:
- Reset/basic route (WIDTH=8, CHANNELS=4): assert rst 2 cycles, then check all outputs are 0. Send s_sel=2, s_data=0xA5 with m_ready=4'b1111 → next cycle m_valid=4'b0100 and m_data[23:16]=0xA5; m_valid=0 the cycle after.
- Backpressure: m_ready[1]=0. Send 0x11 to ch1, then 0x22 to ch1 → second transfer sees s_ready=0 and m_data[15:8] holds 0x11. Raise m_ready[1] → 0x11 drains, 0x22 loads on the same edge, m_valid[1] stays 1.
- Channel independence: ch0 stalled holding 0x33. Back-to-back transfers 0x44 → ch3 and 0x55 → ch2 → both accepted with s_ready=1 and delivered; ch0 still holds 0x33.
- Full throughput: m_ready=all 1. Stream 8 consecutive transfers to ch0 with data 0x00..0x07 → s_ready=1 every cycle; ch0 delivers 0x00..0x07 in order on 8 consecutive cycles.
- Out-of-range (CHANNELS=3, SEL_W=2): send s_sel=3 ×300 → m_valid stays 0, drop_cnt=255 (saturated), err=1. Then rst → drop_cnt=0, err=0.
- Reset mid-operation: ch2 full with 0x77 and m_ready[2]=0. Assert rst while s_valid=1 targets ch2 → after the edge m_valid=0 and no data is delivered. The next in-range transfer proceeds normally.

Source files
------------

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per channel.
// Out-of-range selects are accepted, discarded and counted.
module stream_demux_1ton #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  input  logic [SEL_W-1:0]          s_sel,
  output logic [CHANNELS-1:0]       m_valid,
  input  logic [CHANNELS-1:0]       m_ready,
  output logic [CHANNELS*WIDTH-1:0] m_data,
  output logic [7:0]                drop_cnt,
  output logic                      err
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                in_range;
  logic [CHANNELS-1:0] load;
  logic                drop;

  // Decode the select: ready follows the addressed channel, out-of-range is always ready
  always_comb begin
    s_ready  = 1'b1;
    in_range = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s_sel == SEL_W'(i)) begin
        in_range = 1'b1;
        s_ready  = !m_valid[i] || m_ready[i];
      end
    end
  end

  // Per-channel load strobes and the drop strobe for discarded transfers
  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = s_valid && s_ready && (s_sel == SEL_W'(i));
    end
    drop = s_valid && !in_range;
  end

  // Holding registers: refill wins over drain, drain without refill empties the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      m_data  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i]) begin
          m_valid[i]                 <= 1'b1;
          m_data[i*WIDTH +: WIDTH]   <= s_data;
        end else if (m_ready[i]) begin
          m_valid[i]                 <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
      if (drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: queue-based reference model plus directed and random scenarios.
module tb_stream_demux_1ton;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (4 channels)
  logic            rst, s_valid, s_ready, err;
  logic [W-1:0]    s_data;
  logic [SW-1:0]   s_sel;
  logic [CH-1:0]   m_valid, m_ready;
  logic [CH*W-1:0] m_data;
  logic [7:0]      drop_cnt;

  // Second instance (3 channels) for out-of-range selects
  logic            rst3, s_valid3, s_ready3, err3;
  logic [W-1:0]    s_data3;
  logic [SW-1:0]   s_sel3;
  logic [2:0]      m_valid3, m_ready3;
  logic [3*W-1:0]  m_data3;
  logic [7:0]      drop_cnt3;

  stream_demux_1ton #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sel(s_sel), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .drop_cnt(drop_cnt), .err(err));

  stream_demux_1ton #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW)) dut3 (
    .clk(clk), .rst(rst3), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .s_sel(s_sel3), .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3),
    .drop_cnt(drop_cnt3), .err(err3));

  int checks   = 0;
  int failures = 0;

  // Reference model: items accepted but not yet delivered, and items delivered, per channel
  logic [W-1:0] q[CH][$];
  logic [W-1:0] dlv[CH][$];
  bit           last_acc;

  function automatic bit exp_ready();
    if (int'(s_sel) >= int'(CH)) return 1'b1;
    return (q[s_sel].size() == 0) || m_ready[s_sel];
  endfunction

  // One clock: compare at the falling edge, advance the model for the coming rising edge
  task automatic tick();
    logic [CH-1:0] ev;
    bit acc;
    @(negedge clk);
    checks++;
    if (s_ready !== exp_ready()) begin
      failures++;
      $display("FAIL s_ready t=%0t got=%b exp=%b", $time, s_ready, exp_ready());
    end
    ev = '0;
    for (int i = 0; i < CH; i++) ev[i] = (q[i].size() != 0);
    checks++;
    if (m_valid !== ev) begin
      failures++;
      $display("FAIL m_valid t=%0t got=%b exp=%b", $time, m_valid, ev);
    end
    for (int i = 0; i < CH; i++) begin
      if (q[i].size() != 0) begin
        checks++;
        if (m_data[i*W +: W] !== q[i][0]) begin
          failures++;
          $display("FAIL m_data ch%0d t=%0t got=%h exp=%h", i, $time, m_data[i*W +: W], q[i][0]);
        end
      end
    end
    acc = s_valid && exp_ready();
    if (rst) begin
      for (int i = 0; i < CH; i++) q[i].delete();
      acc = 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (m_ready[i] && q[i].size() != 0) dlv[i].push_back(q[i].pop_front());
      end
      if (acc && int'(s_sel) < int'(CH)) q[s_sel].push_back(s_data);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] sel, input logic [W-1:0] d);
    s_valid = 1'b1; s_sel = sel; s_data = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_sel = '0; s_data = '0; m_ready = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (m_valid !== '0 || m_data !== '0 || drop_cnt !== 8'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h cnt=%0d err=%b exp all zero",
               m_valid, m_data, drop_cnt, err);
    end
  endtask

  task automatic test_basic_route();
    m_ready = '1;
    send(2'd2, 8'hA5);
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 4'b0100 || m_data[23:16] !== 8'hA5) begin
      failures++;
      $display("FAIL basic_route got v=%b d=%h exp v=0100 d=a5", m_valid, m_data[23:16]);
    end
    tick();
    checks++;
    if (m_valid !== 4'b0000) begin
      failures++;
      $display("FAIL basic_drain got v=%b exp 0000", m_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    m_ready = 4'b1101;
    send(2'd1, 8'h11);
    tick();
    send(2'd1, 8'h22);
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall_ready got=%b exp=0", s_ready);
    end
    tick();
    checks++;
    if (m_data[15:8] !== 8'h11) begin
      failures++;
      $display("FAIL bp_hold got=%h exp=11", m_data[15:8]);
    end
    n = dlv[1].size();
    m_ready = 4'b1111;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%b exp=1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid[1] !== 1'b1 || m_data[15:8] !== 8'h22 || dlv[1].size() != n + 1 ||
        dlv[1][n] !== 8'h11) begin
      failures++;
      $display("FAIL bp_refill got v1=%b d=%h exp v1=1 d=22 after 11 drained",
               m_valid[1], m_data[15:8]);
    end
    tick();
  endtask

  task automatic test_independence();
    int n3, n2;
    n3 = dlv[3].size(); n2 = dlv[2].size();
    m_ready = 4'b1110;
    send(2'd0, 8'h33);
    tick();
    send(2'd3, 8'h44);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL indep_ready_ch3 got=%b exp=1", s_ready);
    end
    tick();
    send(2'd2, 8'h55);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL indep_ready_ch2 got=%b exp=1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    tick();
    checks++;
    if (dlv[3].size() != n3 + 1 || dlv[2].size() != n2 + 1 || dlv[3][n3] !== 8'h44 ||
        dlv[2][n2] !== 8'h55 || m_valid[0] !== 1'b1 || m_data[7:0] !== 8'h33) begin
      failures++;
      $display("FAIL indep got v0=%b d0=%h exp v0=1 d0=33 with 44/55 delivered",
               m_valid[0], m_data[7:0]);
    end
    m_ready = '1;
    tick();
  endtask

  task automatic test_full_throughput();
    dlv[0].delete();
    m_ready = '1;
    for (int k = 0; k < 8; k++) begin
      send(2'd0, W'(k));
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL thru_ready k=%0d got=%b exp=1", k, s_ready);
      end
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    checks++;
    if (dlv[0].size() != 8) begin
      failures++;
      $display("FAIL thru_count got=%0d exp=8", dlv[0].size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (dlv[0][k] !== W'(k)) begin
          failures++;
          $display("FAIL thru_order k=%0d got=%h exp=%h", k, dlv[0][k], W'(k));
        end
      end
    end
  endtask

  task automatic test_random();
    last_acc = 1'b1;
    s_valid  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(s_valid && !last_acc)) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_sel   = SW'($urandom_range(0, CH - 1));
        s_data  = W'($urandom);
      end
      m_ready = CH'($urandom);
      #1;
      tick();
    end
    s_valid = 1'b0;
    m_ready = '1;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int n;
    m_ready = 4'b1011;
    send(2'd2, 8'h77);
    tick();
    n = dlv[2].size();
    send(2'd2, 8'h88);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 4'b0000 || dlv[2].size() != n) begin
      failures++;
      $display("FAIL reset_mid got v=%b exp 0000 with nothing delivered", m_valid);
    end
    m_ready = '1;
    send(2'd2, 8'h99);
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 4'b0100 || m_data[23:16] !== 8'h99) begin
      failures++;
      $display("FAIL reset_mid_resume got v=%b d=%h exp v=0100 d=99", m_valid, m_data[23:16]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    int exp_cnt;
    rst3 = 1'b1; s_valid3 = 1'b0; s_sel3 = '0; s_data3 = '0; m_ready3 = '1;
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    s_valid3 = 1'b1; s_sel3 = 2'd3;
    exp_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      s_data3 = W'($urandom);
      #1;
      if (s_ready3 !== 1'b1) begin
        checks++; failures++;
        $display("FAIL oor_ready k=%0d got=%b exp=1", k, s_ready3);
      end
      @(posedge clk);
      #1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (k == 0 || k == 100 || k == 299) begin
        checks++;
        if (m_valid3 !== 3'b000 || drop_cnt3 !== 8'(exp_cnt) || err3 !== 1'b1) begin
          failures++;
          $display("FAIL oor_drop k=%0d got v=%b cnt=%0d err=%b exp v=000 cnt=%0d err=1",
                   k, m_valid3, drop_cnt3, err3, exp_cnt);
        end
      end
    end
    s_valid3 = 1'b0;
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    checks++;
    if (drop_cnt3 !== 8'd0 || err3 !== 1'b0) begin
      failures++;
      $display("FAIL oor_reset got cnt=%0d err=%b exp 0/0", drop_cnt3, err3);
    end
    s_valid3 = 1'b1; s_sel3 = 2'd2; s_data3 = 8'h5A;
    @(posedge clk);
    #1;
    s_valid3 = 1'b0;
    checks++;
    if (m_valid3 !== 3'b100 || m_data3[23:16] !== 8'h5A || drop_cnt3 !== 8'd0) begin
      failures++;
      $display("FAIL oor_inrange got v=%b d=%h cnt=%0d exp v=100 d=5a cnt=0",
               m_valid3, m_data3[23:16], drop_cnt3);
    end
  endtask

  initial begin
    rst3 = 1'b1; s_valid3 = 1'b0; s_sel3 = '0; s_data3 = '0; m_ready3 = '0;
    test_reset();
    test_basic_route();
    test_backpressure();
    test_independence();
    test_full_throughput();
    test_random();
    test_reset_mid();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
